spi_sram_controller: RTL
========================

// Module: spi_sram_controller
// PURPOSE
//   Wishbone B4 classic slave (8-bit data) that serves byte reads and writes from an
//   external 23LC-style serial SPI SRAM. Each Wishbone cycle becomes exactly one SPI
//   READ (0x03) or WRITE (0x02) transaction: 8-bit command, 24-bit address, 8 data bits.
//   Sits between the Levenshtein controller's Wishbone master port (dictionary and
//   bit-vector fetches) and the chip-level SPI pins.
// PARAMETERS
//   ADDR_WIDTH  24     Wishbone address width; must be <=24; zero-extended to 24 bits on SPI
//   READ_CMD    8'h03  SPI opcode for a read
//   WRITE_CMD   8'h02  SPI opcode for a write
// PORTS
//   clk_i      in   1           system clock; the only clock
//   rst_i      in   1           synchronous, active-high reset
//   wbs_cyc_i  in   1           Wishbone cycle
//   wbs_stb_i  in   1           Wishbone strobe
//   wbs_adr_i  in   ADDR_WIDTH  byte address
//   wbs_we_i   in   1           1 = write, 0 = read
//   wbs_dat_i  in   8           write data
//   wbs_ack_o  out  1           one-cycle acknowledge
//   wbs_err_o  out  1           tied 0
//   wbs_rty_o  out  1           tied 0
//   wbs_dat_o  out  8           read data; held until the next read completes
//   spi_sck_o  out  1           SPI clock, mode 0, clk_i/2
//   spi_cs_n_o out  1           SPI chip select, active low
//   spi_mosi_o out  1           controller -> SRAM
//   spi_miso_i in   1           SRAM -> controller
// BEHAVIOUR
//   - Reset: ack=0, dat_o=8'h00, sck=0, cs_n=1, mosi=0, state=IDLE, bit counter=0.
//   - States: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: when cyc&stb&!ack are sampled high at edge N, latch we, the address
//     zero-extended to 24 bits and dat_i into a 40-bit shift register
//     {cmd, addr[23:0], wdata}; wdata=8'h00 for reads. Go to SHIFT.
//   - SHIFT: from edge N+1, cs_n=0. Each of the 40 bits, MSB first, spans 2 clocks:
//     phase A: sck=0, mosi=current bit; phase B: sck=1, and spi_miso_i is sampled at
//     the edge that ends phase B. 6-bit counter 0..39.
//     SHIFT lasts 80 clocks (edges N+1..N+80).
//   - Reads shift the last 8 MISO samples (bits 32..39), MSB first, into the read register.
//     MISO is ignored for bits 0..31 and for all bits of a write.
//   - DONE (edge N+81): cs_n=1, sck=0, mosi=0. ack=1 for exactly this cycle. dat_o =
//     captured byte for reads; unchanged for writes. Next edge returns to IDLE.
//   - ack is 0 in IDLE. A new request is accepted no earlier than the cycle after DONE,
//     so cs_n is high for >=2 clocks between transactions.
//   - Request-to-ack latency is fixed at 81 clocks; no pipelining and no bursts.
//   - If cyc drops during SHIFT: finish the SPI transfer unchanged (the SRAM must not
//     see a truncated frame), suppress ack in DONE, do not update dat_o.
//   - rst_i in SHIFT: the next edge forces the reset values; cs_n rises immediately;
//     no ack.
//   - sck is 0 whenever cs_n=1. All outputs are registered.
// TESTING
//   - Reset: hold rst_i 3 clks -> cs_n=1, sck=0, ack=0, dat_o=8'h00.
//   - Read 0x000200, SRAM model returns 0xA5 -> MOSI 0x03,0x00,0x02,0x00; 40 sck rising
//     edges; ack 81 clks after strobe; dat_o=8'hA5.
//   - Write 8'h3C to 0x00ABCD -> MOSI 0x02,0x00,0xAB,0xCD,0x3C; ack once; then read
//     0x00ABCD -> 8'h3C.
//   - Back-to-back reads of 0x000000 and 0x000001 with stb held high -> two separate
//     frames, cs_n high >=2 clks between frames, exactly 2 ack pulses.
//   - Drop cyc at bit 10 of a read -> frame completes (40 sck), no ack, dat_o unchanged.
//   - Assert rst_i at bit 20 -> cs_n=1 and sck=0 next clk; no ack; next read works.

Source files
------------

// File: rtl/spi_sram_controller.sv
// Wishbone B4 classic byte slave that turns each bus cycle into one 40-bit
// SPI READ/WRITE frame ({cmd, addr[23:0], data}) to a 23LC-style serial SRAM.
module spi_sram_controller #(
  parameter int         ADDR_WIDTH = 24,
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter logic [7:0] WRITE_CMD  = 8'h02
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_RISE  = 2'd1;
  localparam logic [1:0] PH_FALL  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic        we_q, we_d;
  logic        abort_q, abort_d;
  logic [7:0]  rd_q, rd_d;
  logic        ack_q, ack_d;
  logic [7:0]  dat_q, dat_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [23:0] addr_ext;

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_WIDTH-1:0] = wbs_adr_i;
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    we_d      = we_q;
    abort_d   = abort_q;
    rd_d      = rd_q;
    ack_d     = ack_q;
    dat_d     = dat_q;
    sck_d     = sck_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
          shift_d   = {wbs_we_i ? WRITE_CMD : READ_CMD, addr_ext,
                       wbs_we_i ? wbs_dat_i : 8'h00};
          we_d      = wbs_we_i;
          abort_d   = 1'b0;
          bit_cnt_d = '0;
          phase_d   = PH_SETUP;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // A dropped cycle still completes the frame so the SRAM never sees a truncated command.
        if (!wbs_cyc_i) abort_d = 1'b1;
        case (phase_q)
          PH_SETUP: begin
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = shift_q[39];
            phase_d = PH_RISE;
          end
          PH_RISE: begin
            sck_d   = 1'b1;
            phase_d = PH_FALL;
          end
          default: begin
            sck_d = 1'b0;
            if (!we_q && bit_cnt_q >= 6'd32) rd_d = {rd_q[6:0], spi_miso_i};
            if (bit_cnt_q == 6'd39) begin
              cs_n_d  = 1'b1;
              mosi_d  = 1'b0;
              state_d = ST_DONE;
              if (!abort_q && wbs_cyc_i) begin
                ack_d = 1'b1;
                if (!we_q) dat_d = {rd_q[6:0], spi_miso_i};
              end
            end else begin
              shift_d   = {shift_q[38:0], 1'b0};
              mosi_d    = shift_q[38];
              bit_cnt_d = bit_cnt_q + 6'd1;
              phase_d   = PH_RISE;
            end
          end
        endcase
      end

      ST_DONE: begin
        ack_d     = 1'b0;
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_SETUP;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      rd_q      <= '0;
      ack_q     <= 1'b0;
      dat_q     <= 8'h00;
      sck_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      abort_q   <= abort_d;
      rd_q      <= rd_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      sck_q     <= sck_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = 1'b0;
  assign wbs_rty_o  = 1'b0;
  assign wbs_dat_o  = dat_q;
  assign spi_sck_o  = sck_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule
